// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic {RUN, HALT} fetch_state_t;

    localparam logic [31:0] EOF_MARKER = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order FIFO of {instr, pc} with push/pop/flush; the head is
// driven straight from storage registers.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output logic         head_valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer for a 1-cycle synchronous-read memory, with
// redirect and end-of-image halt. Optional counters under FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        halted
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  rsp_pc_q, rsp_pc_d;
    logic         rsp_pending_q, rsp_pending_d;

    logic         deq;
    logic         cap_eof;
    logic         issue;
    logic         push;
    logic [1:0]   buf_count;
    logic [2:0]   occupancy;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic         head_valid;
    logic         unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign deq     = head_valid & instr_ready;
    assign cap_eof = rsp_pending_q && (imem_instr == EOF_MARKER);

    // Slots already committed after this edge: buffered + in flight - leaving.
    assign occupancy = {1'b0, buf_count} + {2'b00, rsp_pending_q} - {2'b00, deq};

    assign issue = (state_q == RUN) && !redirect_valid && !cap_eof &&
                   (occupancy < 3'(BUF_DEPTH));
    assign push  = rsp_pending_q && !cap_eof && !redirect_valid;

    assign push_entry.instr = imem_instr;
    assign push_entry.pc    = rsp_pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        rsp_pending_d = issue;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = {redirect_pc[31:2], 2'b00};
        end else begin
            if (cap_eof) begin
                state_d = HALT;
            end
            if (issue) begin
                pc_d     = pc_q + 32'd4;
                rsp_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= '0;
            rsp_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            rsp_pending_q <= rsp_pending_d;
        end
    end

    fetch_skid_buf u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (deq),
        .flush_i      (redirect_valid),
        .count_o      (buf_count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    assign imem_addr   = pc_q;
    assign instr_valid = head_valid;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign halted      = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (deq) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (head_valid && !instr_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed streams, stalls, redirects,
// end-of-image halt and async reset; counter checks under FETCH_PERF_EN.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int vectors;
    int miscompares;
    exp_t sb [$];
    exp_t got_e;
    logic [31:0] mem [0:1023];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: two known RISC-V words, marker at 0x1FC, filler elsewhere.
    function automatic logic [31:0] mem_word(input int idx);
        if (idx == 0) return 32'h0000_0013;
        if (idx == 1) return 32'h0050_0093;
        if (idx == 127) return 32'hDEAD_BEEF;
        return 32'h0000_0013 | (32'(idx) << 20);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = mem_word(i);
    end

    always @(posedge clk) imem_instr <= mem[imem_addr[11:2]];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every accepted handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_deliver: got pc %h instr %h, expected none",
                         instr_pc, instr);
            end else begin
                got_e = sb.pop_front();
                if (instr_pc !== got_e.pc || instr !== got_e.instr) begin
                    miscompares++;
                    $display("FAIL deliver: got pc %h instr %h, expected pc %h instr %h",
                             instr_pc, instr, got_e.pc, got_e.instr);
                end
            end
        end
    end

    // Expect n sequential words from start; ready held high until all delivered.
    task automatic stream(input logic [31:0] start, input int n, input int exp_cycles);
        int cycles;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            sb.push_back({mem_word(int'(a[11:2])), a});
        end
        instr_ready = 1'b1;
        cycles = 0;
        while (sb.size() != 0 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        instr_ready = 1'b0;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_timeout: got %0d left, expected 0", sb.size());
            sb.delete();
        end
        check("stream_cycles", 32'(cycles), 32'(exp_cycles));
    endtask

    // Entered at posedge+1 with instr_ready low; leaves with head = exp_pc.
    task automatic do_redirect(input logic [31:0] pc, input logic [31:0] exp_pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_gap1_valid", 32'(instr_valid), 32'd0);
        check("redir_halted", 32'(halted), 32'd0);
        @(negedge clk);
        check("redir_gap2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("redir_first_valid", 32'(instr_valid), 32'd1);
        check("redir_first_pc", instr_pc, exp_pc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", imem_addr, 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_edge1_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_edge2_valid", 32'(instr_valid), 32'd1);
        check("lat_edge2_pc", instr_pc, 32'h0);

        // Stall: head must hold at 0x0 and no further issue once full.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_pc", instr_pc, 32'h0);
            check("stall_instr", instr, 32'h0000_0013);
        end
        check("stall_addr", imem_addr, 32'h8);
        @(posedge clk);
        #1;
        stream(32'h0, 5, 5);

        do_redirect(32'h40, 32'h40);
        stream(32'h40, 2, 2);
        do_redirect(32'h43, 32'h40);
        stream(32'h40, 2, 2);

        // End-of-image: marker at 0x1FC.
        do_redirect(32'h1F0, 32'h1F0);
        stream(32'h1F0, 3, 3);
        check("eof_halted", 32'(halted), 32'd1);
        check("eof_valid", 32'(instr_valid), 32'd0);
        check("eof_addr", imem_addr, 32'h200);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt_addr_frozen", imem_addr, 32'h200);
            check("halt_valid", 32'(instr_valid), 32'd0);
        end
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        do_redirect(32'h0, 32'h0);
        stream(32'h0, 2, 2);

        // Fill the buffer, then reset asynchronously mid-cycle.
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        check("async_rst_halted", 32'(halted), 32'd0);
        check("async_rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream(32'h0, 7, 9);
        repeat (3) @(posedge clk);
        #1;
        stream(32'h1C, 3, 3);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 32'd10);
        check("perf_stall", perf_stall, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequences the synchronous-read instruction memory: generates fetch addresses and tracks the 1-cycle read latency.
- Buffers returned words and hands {instr, pc} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and halts on the memory's end-of-image marker 32'hDEADBEEF.
- Sits between the PC/branch logic and decode; the only master of the instruction memory address port.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- BUF_DEPTH, 2, response buffer entries; fixed at 2 (minimum for full throughput at 1-cycle latency); other values unsupported

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  32  byte address to instruction memory; sampled by memory every rising edge
- imem_instr  in  32  memory read data; valid the cycle after the address edge
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 2'b00)
- instr_valid  out  1  output word valid
- instr  out  32  instruction word
- instr_pc  out  32  byte address of instr
- instr_ready  in  1  decode accepts when instr_valid & instr_ready
- halted  out  1  end-of-image marker received; fetch stopped

Behaviour:
- Reset: pc_q=RESET_PC, state=RUN, rsp_pending=0, buffer empty. instr_valid=0, instr=0, instr_pc=0, halted=0. imem_addr=pc_q (combinational).
- States: RUN (issuing), HALT (no issue; halted=1). No IDLE state.
- Issue rule in RUN: issue at an edge when (buf_count + rsp_pending − deq) < 2, where deq = instr_valid & instr_ready. On issue: rsp_pending<=1, rsp_pc<=pc_q, pc_q<=pc_q+4. Address wraps modulo 2^32.
- No issue: rsp_pending<=0. imem_addr still shows pc_q; the memory reads it, but the result is ignored.
- Response capture: if rsp_pending, imem_instr is written into the buffer with rsp_pc at the next edge.
- End-of-image: if the captured word == 32'hDEADBEEF:
  - the word is not enqueued;
  - state<=HALT, halted<=1;
  - any same-cycle issue is squashed (rsp_pending<=0);
  - pc_q is held at the marker address + 4 (value irrelevant).
- Already-buffered words drain normally in HALT.
- Latency: first rising edge after rst_n release issues RESET_PC; instr_valid=1 after the second edge. Sustains 1 instr/cycle with instr_ready held high.
- Buffer: 2-entry FIFO, in-order. Head drives instr/instr_pc/instr_valid directly from registers (no comb path from imem_instr to outputs). instr/instr_pc hold stable while instr_valid & !instr_ready.
- Redirect (any state, highest priority):
  - buffer flushed, rsp_pending<=0 (in-flight response discarded), pc_q<={redirect_pc[31:2],2'b00};
  - state<=RUN, halted<=0;
  - no issue that edge, so the first new address is sampled the edge after;
  - instr_valid=0 the cycle after redirect;
  - a same-cycle deq is treated as accepted but is flushed regardless.
- Redirect while halted: resumes fetching at the new pc.
- Full buffer + pending response: cannot occur, because the issue rule guarantees space.
- Reset asserted mid-operation: all state returns to reset values immediately (async).

Optional Feature:
- FETCH_PERF_EN
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0, wrapping.
  - perf_fetched increments on each accepted handshake.
  - perf_stall increments each cycle instr_valid & !instr_ready.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic {RUN, HALT} fetch_state_t;
  - localparam EOF_MARKER = 32'hDEADBEEF;
  - typedef struct packed {logic [31:0] instr; logic [31:0] pc;} fetch_entry_t.
- Sub-module fetch_skid_buf: 2-entry fetch_entry_t FIFO with push/pop/flush, count[1:0], head outputs.
- Top fetch_unit: FSM, pc_q, issue/pending logic.

Test Plan:
- Reset release, memory words 0x00000013,0x00500093,… at 0x0,0x4, instr_ready=1 -> instr_valid after 2nd edge; pc 0x0,0x4,0x8 on consecutive cycles; instr matches memory.
- instr_ready low 5 cycles after first valid -> instr/instr_pc stable (pc 0x0); buffer holds 0x4; no issue while full; on release, 0x0,0x4,0x8 delivered with no gaps or duplicates.
- redirect_valid with redirect_pc=0x40 while streaming at 0x10 -> the word at 0x14 in flight is dropped; instr_valid=0 for 2 cycles; next delivered pc=0x40. With redirect_pc=0x43, next delivered pc is 0x40.
- Word at 0x1FC is 0xDEADBEEF -> words up to 0x1F8 delivered, halted=1, marker never valid, imem_addr frozen; then redirect to 0x0 -> halted=0, fetch resumes at 0x0.
- rst_n pulsed low mid-stream with buffer full -> instr_valid and halted drop immediately; restart delivers RESET_PC first.
- FETCH_PERF_EN defined: 10 accepted instrs and 3 stall cycles -> perf_fetched=10, perf_stall=3.
